// File: rtl/fifo_sink_pkg.sv
// Shared constants and FSM state encoding for the FIFO drain sink.
package fifo_sink_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CAP_DEPTH  = 32;
    localparam int CAP_AW         = $clog2(DEF_CAP_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_CAPTURE,
        ST_GAP,
        ST_DONE
    } sink_state_e;

endpackage

// File: rtl/fifo_drain_sink_if.sv
// FIFO read-side port: the sink drives the read request, the FIFO returns empty and data.
interface fifo_drain_sink_if
    import fifo_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;

    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_drain_sink_cap_ram.sv
// Capture RAM for the drain sink: one write port, one registered read port.
module sink_cap_ram
    import fifo_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_CAP_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  rd_clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register resets.
    always_ff @(posedge rd_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // NOTE: non-blocking assignment here means a same-cycle read of wr_addr returns the old word.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) rd_data <= '0;
        else          rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_drain_sink.sv
// Read-side FIFO consumer: pulls one word per read pulse into a capture RAM.
// Optional running checksum enabled by defining SINK_CHECKSUM_EN.
module fifo_drain_sink
    import fifo_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CAP_DEPTH  = DEF_CAP_DEPTH,
    parameter int CNT_W      = $clog2(CAP_DEPTH) + 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                         rd_clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         stop,
    fifo_drain_sink_if.master            fifo,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             word_count,
    output logic [DATA_WIDTH-1:0]        last_word,
    input  logic [$clog2(CAP_DEPTH)-1:0] cap_addr,
    output logic [DATA_WIDTH-1:0]        cap_data,
    output logic [DATA_WIDTH-1:0]        checksum
);
    localparam int AW       = $clog2(CAP_DEPTH);
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    sink_state_e   state_q, state_d;
    logic [GW-1:0] gap_q;
    logic          rd_en_q;
    logic          cap_we;
    logic          cap_last;
    logic          session_start;

    assign session_start = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign cap_we        = (state_q == ST_CAPTURE) && (word_count < CNT_W'(CAP_DEPTH));
    assign cap_last      = (word_count == CNT_W'(CAP_DEPTH - 1));
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);
    assign fifo.fifo_rd_en = rd_en_q;

    always_comb begin
        // NOTE: default first so no branch leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ARM;
            ST_ARM:     if (stop) state_d = ST_DONE;
                        else if (!fifo.fifo_empty) state_d = ST_WAIT;
            ST_WAIT:    state_d = ST_CAPTURE;
            ST_CAPTURE: if (cap_last || stop) state_d = ST_DONE;
                        else if (GAP_CYCLES == 0) state_d = ST_ARM;
                        else state_d = ST_GAP;
            ST_GAP:     if (stop) state_d = ST_DONE;
                        else if (gap_q == GW'(GAP_LAST)) state_d = ST_ARM;
            ST_DONE:    if (start) state_d = ST_ARM;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Read pulse is high exactly while the FSM sits in WAIT, from a flop rather than a decode.
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rd_en_q    <= 1'b0;
            gap_q      <= '0;
            word_count <= '0;
            last_word  <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= (state_d == ST_WAIT);
            if (state_q == ST_CAPTURE) gap_q <= '0;
            else if (state_q == ST_GAP) gap_q <= gap_q + GW'(1);
            if (session_start) begin
                word_count <= '0;
            end else if (cap_we) begin
                word_count <= word_count + CNT_W'(1);
                last_word  <= fifo.fifo_data;
            end
        end
    end

`ifdef SINK_CHECKSUM_EN
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n)          checksum <= '0;
        else if (session_start) checksum <= '0;
        else if (cap_we)        checksum <= checksum + fifo.fifo_data;
    end
`else
    assign checksum = '0;
`endif

    sink_cap_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CAP_DEPTH)
    ) u_cap_ram (
        .rd_clk  (rd_clk),
        .reset_n (reset_n),
        .wr_en   (cap_we),
        .wr_addr (word_count[AW-1:0]),
        .wr_data (fifo.fifo_data),
        .rd_addr (cap_addr),
        .rd_data (cap_data)
    );
endmodule

// File: tb/tb_fifo_drain_sink.sv
// Self-checking bench for fifo_drain_sink: queue-based FIFO model, randomized words, expected
// captures, spacing and checksum derived from the behavioural rules.
module tb_fifo_drain_sink;
    import fifo_sink_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int CW    = 6;
    localparam int AW    = 5;

    logic          rd_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic          busy, done;
    logic [CW-1:0] word_count;
    logic [DW-1:0] last_word, cap_data, checksum;

    logic          start_g = 1'b0, stop_g = 1'b0;
    logic [AW-1:0] cap_addr_g = '0;
    logic          busy_g, done_g;
    logic [CW-1:0] word_count_g;
    logic [DW-1:0] last_word_g, cap_data_g, checksum_g;

    fifo_drain_sink_if #(.DATA_WIDTH(DW)) fif ();
    fifo_drain_sink_if #(.DATA_WIDTH(DW)) gif ();

    fifo_drain_sink #(.DATA_WIDTH(DW), .CAP_DEPTH(DEPTH), .CNT_W(CW), .GAP_CYCLES(0)) dut (
        .rd_clk(rd_clk), .reset_n(reset_n), .start(start), .stop(stop), .fifo(fif),
        .busy(busy), .done(done), .word_count(word_count), .last_word(last_word),
        .cap_addr(cap_addr), .cap_data(cap_data), .checksum(checksum)
    );

    fifo_drain_sink #(.DATA_WIDTH(DW), .CAP_DEPTH(DEPTH), .CNT_W(CW), .GAP_CYCLES(2)) dut_g (
        .rd_clk(rd_clk), .reset_n(reset_n), .start(start_g), .stop(stop_g), .fifo(gif),
        .busy(busy_g), .done(done_g), .word_count(word_count_g), .last_word(last_word_g),
        .cap_addr(cap_addr_g), .cap_data(cap_data_g), .checksum(checksum_g)
    );

    always #5 rd_clk = ~rd_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses[$];
    int pulses_g[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] model_mem [DEPTH];

    // FIFO model: registered data on a read pulse, registered empty flag.
    always @(posedge rd_clk) begin
        cyc <= cyc + 1;
        if (fif.fifo_rd_en === 1'b1 && fq.size() > 0) begin
            fif.fifo_data <= fq[0];
            fq.pop_front();
        end
        fif.fifo_empty <= (fq.size() == 0);
        gif.fifo_empty <= 1'b0;
        if (gif.fifo_rd_en === 1'b1) gif.fifo_data <= DW'($urandom);
    end

    always @(negedge rd_clk) begin
        if (fif.fifo_rd_en === 1'b1) pulses.push_back(cyc);
        if (gif.fifo_rd_en === 1'b1) pulses_g.push_back(cyc);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge rd_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) until the n-th read pulse of the current session is visible.
    task automatic wait_rd_pulses(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < 100 && seen < n; i++) begin
            tick();
            if (fif.fifo_rd_en === 1'b1) seen++;
        end
        if (seen < n) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got %0d pulses exp %0d", tag, seen, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        n_cmp++; if (fif.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b exp 0", fif.fifo_rd_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b exp 0", done); end
        n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL reset_wc: got %0d exp 0", word_count); end
        n_cmp++; if (last_word !== '0) begin n_bad++; $display("FAIL reset_last: got %0d exp 0", last_word); end
        n_cmp++; if (cap_data !== '0) begin n_bad++; $display("FAIL reset_cap_data: got %0d exp 0", cap_data); end
        n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL reset_checksum: got %0d exp 0", checksum); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_partial_drain();
        logic [DW-1:0] words [3] = '{16'd111, 16'd222, 16'd333};
        foreach (words[i]) begin fq.push_back(words[i]); model_mem[i] = words[i]; end
        tick();
        pulses.delete();
        pulse_start();
        tick(25);
        n_cmp++; if (pulses.size() != 3) begin n_bad++; $display("FAIL partial_pulses: got %0d exp 3", pulses.size()); end
        for (int i = 1; i < pulses.size(); i++) begin
            n_cmp++;
            if (pulses[i] - pulses[i-1] != 3) begin n_bad++; $display("FAIL partial_spacing: got %0d exp 3", pulses[i] - pulses[i-1]); end
        end
        n_cmp++; if (word_count !== CW'(3)) begin n_bad++; $display("FAIL partial_wc: got %0d exp 3", word_count); end
        n_cmp++; if (last_word !== words[2]) begin n_bad++; $display("FAIL partial_last: got %0d exp %0d", last_word, words[2]); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL partial_busy: got %b exp 1", busy); end
    endtask

    task automatic test_start_while_busy();
        pulse_start();
        tick(5);
        n_cmp++; if (word_count !== CW'(3)) begin n_bad++; $display("FAIL busy_start_wc: got %0d exp 3", word_count); end
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL busy_start_state: got busy=%b done=%b exp busy=1 done=0", busy, done); end
        stop = 1'b1;
        tick(2);
        stop = 1'b0;
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stop_in_arm_done: got %b exp 1", done); end
        n_cmp++; if (word_count !== CW'(3)) begin n_bad++; $display("FAIL stop_in_arm_wc: got %0d exp 3", word_count); end
    endtask

    task automatic test_full_capture();
        logic [DW-1:0] words [DEPTH];
        logic [DW-1:0] sum = '0;
        logic [DW-1:0] exp_sum;
        int bad_gap = 0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = DW'($urandom);
            sum = sum + words[i];
            fq.push_back(words[i]);
            model_mem[i] = words[i];
        end
        tick();
        pulses.delete();
        pulse_start();
        for (int i = 0; i < 300 && done !== 1'b1; i++) tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b exp 1", done); end
        tick(10);
        n_cmp++; if (word_count !== CW'(DEPTH)) begin n_bad++; $display("FAIL full_wc: got %0d exp %0d", word_count, DEPTH); end
        n_cmp++; if (pulses.size() != DEPTH) begin n_bad++; $display("FAIL full_pulses: got %0d exp %0d", pulses.size(), DEPTH); end
        for (int i = 1; i < pulses.size(); i++) if (pulses[i] - pulses[i-1] != 3) bad_gap++;
        n_cmp++; if (bad_gap != 0) begin n_bad++; $display("FAIL full_spacing: got %0d bad gaps exp 0", bad_gap); end
        n_cmp++; if (last_word !== words[DEPTH-1]) begin n_bad++; $display("FAIL full_last: got %0d exp %0d", last_word, words[DEPTH-1]); end
`ifdef SINK_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = '0;
`endif
        n_cmp++; if (checksum !== exp_sum) begin n_bad++; $display("FAIL full_checksum: got %0d exp %0d", checksum, exp_sum); end
        for (int i = 0; i < DEPTH; i++) begin
            cap_addr = AW'(i);
            tick();
            n_cmp++;
            if (cap_data !== words[i]) begin n_bad++; $display("FAIL full_readback[%0d]: got %0d exp %0d", i, cap_data, words[i]); end
        end
    endtask

    task automatic test_start_in_done();
        pulse_start();
        n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL done_start_wc: got %0d exp 0", word_count); end
        n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL done_start_state: got done=%b busy=%b exp done=0 busy=1", done, busy); end
        n_cmp++; if (checksum !== '0) begin n_bad++; $display("FAIL done_start_checksum: got %0d exp 0", checksum); end
    endtask

    task automatic test_stop_inflight();
        logic [DW-1:0] words [4];
        logic [DW-1:0] exp_sum;
        int stop_cyc, late;
        for (int i = 0; i < 4; i++) begin words[i] = DW'($urandom); fq.push_back(words[i]); end
        wait_rd_pulses(2, "stop");
        stop = 1'b1;
        stop_cyc = cyc;
        tick(4);
        n_cmp++; if (word_count !== CW'(2)) begin n_bad++; $display("FAIL stop_wc: got %0d exp 2", word_count); end
        n_cmp++; if (last_word !== words[1]) begin n_bad++; $display("FAIL stop_last: got %0d exp %0d", last_word, words[1]); end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL stop_state: got done=%b busy=%b exp done=1 busy=0", done, busy); end
        tick(6);
        late = 0;
        foreach (pulses[i]) if (pulses[i] > stop_cyc) late++;
        n_cmp++; if (late != 0) begin n_bad++; $display("FAIL stop_extra_rd_en: got %0d exp 0", late); end
`ifdef SINK_CHECKSUM_EN
        exp_sum = words[0] + words[1];
`else
        exp_sum = '0;
`endif
        n_cmp++; if (checksum !== exp_sum) begin n_bad++; $display("FAIL stop_checksum: got %0d exp %0d", checksum, exp_sum); end
        stop = 1'b0;
        model_mem[0] = words[0];
        model_mem[1] = words[1];
    endtask

    task automatic test_reset_in_wait();
        logic [DW-1:0] r [4];
        logic [DW-1:0] s [3];
        reset_n = 1'b0;
        fq.delete();
        tick(2);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin r[i] = DW'($urandom); fq.push_back(r[i]); end
        tick();
        pulse_start();
        wait_rd_pulses(2, "rst_wait");
        reset_n = 1'b0;
        #1;
        n_cmp++; if (fif.fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_wait_rd_en: got %b exp 0", fif.fifo_rd_en); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_wait_state: got busy=%b done=%b exp 0 0", busy, done); end
        n_cmp++; if (word_count !== '0 || last_word !== '0) begin n_bad++; $display("FAIL rst_wait_count: got wc=%0d last=%0d exp 0 0", word_count, last_word); end
        n_cmp++; if (cap_data !== '0 || checksum !== '0) begin n_bad++; $display("FAIL rst_wait_data: got cap=%0d sum=%0d exp 0 0", cap_data, checksum); end
        tick(2);
        fq.delete();
        reset_n = 1'b1;
        tick();
        model_mem[0] = r[0];
        for (int i = 0; i < 2; i++) begin
            cap_addr = AW'(i);
            tick();
            n_cmp++;
            if (cap_data !== model_mem[i]) begin n_bad++; $display("FAIL rst_wait_mem[%0d]: got %0d exp %0d", i, cap_data, model_mem[i]); end
        end
        for (int i = 0; i < 3; i++) begin s[i] = DW'($urandom); fq.push_back(s[i]); model_mem[i] = s[i]; end
        tick();
        pulse_start();
        for (int i = 0; i < 50 && word_count !== CW'(3); i++) tick();
        tick(2);
        n_cmp++; if (word_count !== CW'(3)) begin n_bad++; $display("FAIL rerun_wc: got %0d exp 3", word_count); end
        n_cmp++; if (last_word !== s[2]) begin n_bad++; $display("FAIL rerun_last: got %0d exp %0d", last_word, s[2]); end
        for (int i = 0; i < 3; i++) begin
            cap_addr = AW'(i);
            tick();
            n_cmp++;
            if (cap_data !== model_mem[i]) begin n_bad++; $display("FAIL rerun_mem[%0d]: got %0d exp %0d", i, cap_data, model_mem[i]); end
        end
    endtask

    task automatic test_gap_spacing();
        int bad_gap = 0;
        pulses_g.delete();
        start_g = 1'b1;
        tick();
        start_g = 1'b0;
        tick(45);
        n_cmp++; if (pulses_g.size() < 6) begin n_bad++; $display("FAIL gap_pulses: got %0d exp at least 6", pulses_g.size()); end
        for (int i = 1; i < pulses_g.size(); i++) if (pulses_g[i] - pulses_g[i-1] != 5) bad_gap++;
        n_cmp++; if (bad_gap != 0) begin n_bad++; $display("FAIL gap_spacing: got %0d bad gaps exp 0", bad_gap); end
        n_cmp++; if (busy_g !== 1'b1) begin n_bad++; $display("FAIL gap_busy: got %b exp 1", busy_g); end
    endtask

    initial begin
        test_reset();
        test_partial_drain();
        test_start_while_busy();
        test_full_capture();
        test_start_in_done();
        test_stop_inflight();
        test_reset_in_wait();
        test_gap_spacing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
